switch_debounce_pio: RTL and testbench



---
 rtl/switch_debounce_pio.sv | 125 ++++++++++++
 tb/tb_switch_debounce_pio.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_pio.sv
// switch_debounce_pio: synchronised, per-bit debounced switch/button input port
// with edge capture and a maskable level interrupt on a 4-word Avalon-MM slave.
module switch_debounce_pio #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] edgecapture_q, edgecapture_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign sync         = sync_q[SYNC_STAGES-1];
    assign wr_en        = chipselect & ~write_n;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb begin
                db_d = sync;
                upd  = sync ^ db_q;
            end
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

            // Any sample matching the debounced level restarts that bit's count.
            always_comb begin
                db_d  = db_q;
                upd   = '0;
                cnt_d = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync[i] != db_q[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            db_d[i] = sync[i];
                            upd[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        case (EDGE_TYPE)
            0:       qual = upd & db_d;
            1:       qual = upd & ~db_d;
            default: qual = upd;
        endcase
    end

    // Set takes priority over a simultaneous write-1-to-clear.
    always_comb begin
        clr           = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edgecapture_d = (edgecapture_q & ~clr) | qual;
        irqmask_d     = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : irqmask_q;
    end

    always_comb begin
        case (address)
            2'd0:    readdata_d = 32'(db_q);
            2'd1:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edgecapture_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            db_q          <= '0;
            edgecapture_q <= '0;
            irqmask_q     <= '0;
            readdata_q    <= '0;
        end else begin
            sync_q        <= sync_d;
            db_q          <= db_d;
            edgecapture_q <= edgecapture_d;
            irqmask_q     <= irqmask_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_switch_debounce_pio.sv
// Directed testbench for switch_debounce_pio: main instance (debounce 4, any edge)
// plus rising-only, falling-only and bypass instances sharing the bus.
module tb_switch_debounce_pio;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port, in_port_e, in_port_b;
    logic [31:0] rd, rd_e0, rd_e1, rd_b;
    logic        irq, irq_e0, irq_e1, irq_b;

    int n_checks;
    int n_fail;

    switch_debounce_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd), .irq(irq)
    );

    switch_debounce_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_e0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_e),
        .readdata(rd_e0), .irq(irq_e0)
    );

    switch_debounce_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_e1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_e),
        .readdata(rd_e1), .irq(irq_e1)
    );

    switch_debounce_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(rd_b), .irq(irq_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives a one-cycle write starting at the current negedge; returns at the next negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic test_reset;
        in_port = 8'hFF;
        address = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd !== 32'h0 || irq !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold: readdata=%h irq=%b, required 0/0", rd, irq);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd !== ((k >= 7) ? 32'hFF : 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL reset_release_db cycle %0d: got %h required %h",
                         k, rd, (k >= 7) ? 32'hFF : 32'h0);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_irq_masked: got %b required 0", irq);
        end
    endtask

    task automatic test_debounce;
        in_port = 8'h00;
        repeat (10) @(negedge clk);
        bus_write(2'd3, 32'hFF);
        address = 2'd0;
        in_port = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd !== ((k >= 7) ? 32'h01 : 32'h00)) begin
                n_fail++;
                $display("[TB] FAIL debounce_latency cycle %0d: got %h required %h",
                         k, rd, (k >= 7) ? 32'h01 : 32'h00);
            end
        end
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL debounce_capture: got %h required 00000001", rd);
        end
        in_port[1] = 1'b1;
        repeat (3) @(negedge clk);
        in_port[1] = 1'b0;
        repeat (10) @(negedge clk);
        address = 2'd0;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL glitch_db: got %h required 00000001", rd);
        end
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL glitch_capture: got %h required 00000001", rd);
        end
    endtask

    task automatic test_interrupt;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_before_mask: got %b required 0", irq);
        end
        bus_write(2'd1, 32'h01);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_after_mask: got %b required 1", irq);
        end
        address = 2'd1;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL mask_readback: got %h required 00000001", rd);
        end
        bus_write(2'd3, 32'h01);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_after_clear: got %b required 0", irq);
        end
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL capture_after_clear: got %h required 00000000", rd);
        end
    endtask

    task automatic test_collision;
        in_port = 8'h05;
        repeat (5) @(negedge clk);
        bus_write(2'd3, 32'h04);
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h04) begin
            n_fail++;
            $display("[TB] FAIL collision_set_wins: got %h required 00000004", rd);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL collision_irq_masked: got %b required 0", irq);
        end
        bus_write(2'd3, 32'h04);
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL plain_clear: got %h required 00000000", rd);
        end
    endtask

    task automatic test_simultaneous;
        in_port = 8'h3D;
        repeat (10) @(negedge clk);
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h38) begin
            n_fail++;
            $display("[TB] FAIL multi_capture: got %h required 00000038", rd);
        end
        address = 2'd0;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h3D) begin
            n_fail++;
            $display("[TB] FAIL multi_db: got %h required 0000003d", rd);
        end
        bus_write(2'd1, 32'h20);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multi_irq_set: got %b required 1", irq);
        end
        bus_write(2'd3, 32'h38);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL multi_irq_clear: got %b required 0", irq);
        end
    endtask

    task automatic test_edge_type;
        in_port_e = 8'h01;
        repeat (10) @(negedge clk);
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd_e0 !== 32'h01 || rd_e1 !== 32'h00) begin
            n_fail++;
            $display("[TB] FAIL edge_rise: rising-only=%h falling-only=%h, required 01/00", rd_e0, rd_e1);
        end
        bus_write(2'd3, 32'hFF);
        in_port_e = 8'h00;
        repeat (10) @(negedge clk);
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd_e0 !== 32'h00 || rd_e1 !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL edge_fall: rising-only=%h falling-only=%h, required 00/01", rd_e0, rd_e1);
        end
    endtask

    task automatic test_bypass;
        address   = 2'd0;
        in_port_b = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd_b !== ((k >= 4) ? 32'h01 : 32'h00)) begin
                n_fail++;
                $display("[TB] FAIL bypass_latency cycle %0d: got %h required %h",
                         k, rd_b, (k >= 4) ? 32'h01 : 32'h00);
            end
        end
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd_b !== 32'h01) begin
            n_fail++;
            $display("[TB] FAIL bypass_capture: got %h required 00000001", rd_b);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'h3C;
        exp_rd[1] = 32'h20;
        exp_rd[2] = 32'h00;
        exp_rd[3] = 32'h01;
        in_port = 8'h3C;
        repeat (10) @(negedge clk);
        bus_write(2'd0, 32'h00);
        bus_write(2'd2, 32'hFF);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            @(negedge clk);
            n_checks++;
            if (rd !== exp_rd[a]) begin
                n_fail++;
                $display("[TB] FAIL read_addr%0d: got %h required %h", a, rd, exp_rd[a]);
            end
        end
    endtask

    task automatic test_reset_midcount;
        in_port = 8'h7C;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: readdata=%h irq=%b, required 0/0", rd, irq);
        end
        reset   = 1'b0;
        address = 2'd1;
        @(negedge clk);
        address = 2'd3;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_capture: got %h required 00000000", rd);
        end
        address = 2'd1;
        @(negedge clk);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_mask: got %h required 00000000", rd);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        in_port_e  = 8'h00;
        in_port_b  = 8'h00;

        test_reset();
        test_debounce();
        test_interrupt();
        test_collision();
        test_simultaneous();
        test_edge_type();
        test_bypass();
        test_back_to_back();
        test_reset_midcount();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
